// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operand width, 6-bit control layout and funct3 encodings.
package alu_pkg;
    localparam int XLEN_DEFAULT = 32;
    typedef struct packed {
        logic       sub;
        logic       ashr;
        logic       w;
        logic [2:0] funct3;
    } alu_ctl_t;
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-way round-robin arbiter; ptr_q names the preferred requester
// and moves to the other requester after every grant.
module alu_rr_arb2 (
    input  logic clock,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic grant0,
    output logic grant1
);
    logic ptr_q, ptr_d;

    always_comb begin
        grant0 = enable & valid0 & (~valid1 | ~ptr_q);
        grant1 = enable & valid1 & (~valid0 | ptr_q);
        ptr_d  = grant0 ? 1'b1 : grant1 ? 1'b0 : ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/alu_issue_arb.sv
// alu_issue_arb: issues two requesters round-robin into a registered ALU stage and response stage.
// Define ALU_ISSUE_ARB_FWD_EN to let a requester substitute its latest result for either operand.
module alu_issue_arb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [5:0]      req0_ctl,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [1:0]      req0_fwd,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [5:0]      req1_ctl,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [1:0]      req1_fwd,
    output logic            alu_sub,
    output logic            alu_ashr,
    output logic            alu_w,
    output logic [2:0]      alu_funct3,
    output logic [XLEN-1:0] alu_op1,
    output logic [XLEN-1:0] alu_op2,
    input  logic [XLEN-1:0] alu_result,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    input  logic            rsp_ready
);
    logic            stall, grant0, grant1, gnt_any, gnt_id;
    alu_ctl_t        gnt_ctl;
    logic [XLEN-1:0] gnt_op1, gnt_op2, iss_op1, iss_op2;
    logic [1:0]      gnt_fwd;
    logic            s1_valid_q, s1_valid_d, s1_id_q, s1_id_d;
    alu_ctl_t        s1_ctl_q, s1_ctl_d;
    logic [XLEN-1:0] s1_op1_q, s1_op1_d, s1_op2_q, s1_op2_d;
    logic            rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;

    assign stall = rsp_valid_q & ~rsp_ready;

    alu_rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable (~stall & ~reset),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        gnt_any = grant0 | grant1;
        gnt_id  = grant1;
        gnt_ctl = gnt_id ? alu_ctl_t'(req1_ctl) : alu_ctl_t'(req0_ctl);
        gnt_op1 = gnt_id ? req1_op1 : req0_op1;
        gnt_op2 = gnt_id ? req1_op2 : req0_op2;
        gnt_fwd = gnt_id ? req1_fwd : req0_fwd;
    end

`ifdef ALU_ISSUE_ARB_FWD_EN
    logic [XLEN-1:0] last_q [2];
    logic [XLEN-1:0] last_d [2];
    logic [XLEN-1:0] fwd_src;

    // A same-requester op still in S1 is newer than last_q, so its live result wins.
    always_comb begin
        last_d = last_q;
        if (~stall & s1_valid_q) last_d[s1_id_q] = alu_result;
        fwd_src = (s1_valid_q && s1_id_q == gnt_id) ? alu_result : last_q[gnt_id];
        iss_op1 = gnt_fwd[1] ? fwd_src : gnt_op1;
        iss_op2 = gnt_fwd[0] ? fwd_src : gnt_op2;
    end

    always_ff @(posedge clock) begin
        if (reset) last_q <= '{default: '0};
        else       last_q <= last_d;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^gnt_fwd;
    assign iss_op1    = gnt_op1;
    assign iss_op2    = gnt_op2;
`endif

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_ctl_d     = s1_ctl_q;
        s1_op1_d     = s1_op1_q;
        s1_op2_d     = s1_op2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (~stall) begin
            s1_valid_d  = gnt_any;
            rsp_valid_d = s1_valid_q;
            if (gnt_any) begin
                s1_id_d  = gnt_id;
                s1_ctl_d = gnt_ctl;
                s1_op1_d = iss_op1;
                s1_op2_d = iss_op2;
            end
            if (s1_valid_q) begin
                rsp_id_d     = s1_id_q;
                rsp_result_d = alu_result;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_ctl_q     <= '0;
            s1_op1_q     <= '0;
            s1_op2_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_id_q      <= s1_id_d;
            s1_ctl_q     <= s1_ctl_d;
            s1_op1_q     <= s1_op1_d;
            s1_op2_q     <= s1_op2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_sub    = s1_ctl_q.sub;
    assign alu_ashr   = s1_ctl_q.ashr;
    assign alu_w      = s1_ctl_q.w;
    assign alu_funct3 = s1_ctl_q.funct3;
    assign alu_op1    = s1_op1_q;
    assign alu_op2    = s1_op2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
endmodule

// File: tb/tb_alu_issue_arb.sv
// tb_alu_issue_arb: random and directed stimulus against a transaction-level model
// (results computed at accept time, responses tracked as pipeline slots).
module tb_alu_issue_arb;
    import alu_pkg::*;
    localparam int XLEN = 32;
    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] SUB = 6'b100000;
`ifdef ALU_ISSUE_ARB_FWD_EN
    localparam logic [XLEN-1:0] EXP42 = 9;
    localparam logic [XLEN-1:0] EXP43 = 3;
`else
    localparam logic [XLEN-1:0] EXP42 = 1;
    localparam logic [XLEN-1:0] EXP43 = 10;
`endif

    logic clock = 1'b0, reset = 1'b1;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [5:0] req0_ctl = '0, req1_ctl = '0;
    logic [XLEN-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic [1:0] req0_fwd = '0, req1_fwd = '0;
    logic alu_sub, alu_ashr, alu_w, rsp_valid, rsp_id, rsp_ready = 1'b1;
    logic [2:0] alu_funct3;
    logic [XLEN-1:0] alu_op1, alu_op2, alu_result, rsp_result;

    int checks = 0, errors = 0;

    typedef struct {
        bit              v;
        bit              id;
        logic [XLEN-1:0] res;
    } slot_t;
    slot_t m_s1, m_s2;
    bit m_ptr;
    logic [XLEN-1:0] m_last [2];

    always #5 clock = ~clock;

    alu_issue_arb #(.XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_fwd(req0_fwd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_fwd(req1_fwd),
        .alu_sub(alu_sub), .alu_ashr(alu_ashr), .alu_w(alu_w), .alu_funct3(alu_funct3),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ready(rsp_ready)
    );

    // External ALU; w means a 16-bit result sign-extended, so the w control is observable.
    function automatic logic [XLEN-1:0] alu_fn(logic [5:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        alu_ctl_t k;
        logic [XLEN-1:0] r;
        k = alu_ctl_t'(c);
        case (k.funct3)
            F3_ADD:  r = k.sub ? a - b : a + b;
            F3_SLL:  r = a << b[4:0];
            F3_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            F3_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = k.ashr ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            F3_OR:   r = a | b;
            default: r = a & b;
        endcase
        if (k.w) r = {{(XLEN-16){r[15]}}, r[15:0]};
        return r;
    endfunction

    always_comb alu_result = alu_fn({alu_sub, alu_ashr, alu_w, alu_funct3}, alu_op1, alu_op2);

    task automatic check(string tag, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Forwarded operands use the most recent accepted result of the same requester.
    function automatic logic [XLEN-1:0] issue(bit id);
        logic [5:0] c;
        logic [XLEN-1:0] a, b;
        logic [1:0] f;
        c = id ? req1_ctl : req0_ctl;
        a = id ? req1_op1 : req0_op1;
        b = id ? req1_op2 : req0_op2;
        f = id ? req1_fwd : req0_fwd;
`ifdef ALU_ISSUE_ARB_FWD_EN
        if (f[1]) a = m_last[id];
        if (f[0]) b = m_last[id];
`else
        f = 2'b00;
`endif
        return alu_fn(c, a, b);
    endfunction

    task automatic cycle();
        bit stall, g0, g1;
        @(negedge clock);
        stall = m_s2.v && !rsp_ready;
        g0 = !reset && !stall && req0_valid && (!req1_valid || !m_ptr);
        g1 = !reset && !stall && req1_valid && (!req0_valid || m_ptr);
        check("ready0", req0_ready, g0);
        check("ready1", req1_ready, g1);
        check("rsp_valid", rsp_valid, m_s2.v);
        if (m_s2.v) begin
            check("rsp_id", rsp_id, m_s2.id);
            check("rsp_result", rsp_result, m_s2.res);
        end
        if (reset) begin
            m_s1 = '{0, 0, '0};
            m_s2 = '{0, 0, '0};
            m_ptr = 0;
            m_last = '{default: '0};
        end else if (!stall) begin
            m_s2 = m_s1;
            m_s1.v = g0 | g1;
            if (g0 | g1) begin
                m_s1.id = g1;
                m_s1.res = issue(g1);
                m_last[g1] = m_s1.res;
                m_ptr = !g1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(bit n, bit v, logic [5:0] c, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [1:0] f);
        if (n) begin
            req1_valid = v; req1_ctl = c; req1_op1 = a; req1_op2 = b; req1_fwd = f;
        end else begin
            req0_valid = v; req0_ctl = c; req0_op1 = a; req0_op2 = b; req0_fwd = f;
        end
    endtask

    task automatic idle();
        set_req(0, 0, ADD, '0, '0, 2'b00);
        set_req(1, 0, ADD, '0, '0, 2'b00);
    endtask

    task automatic do_reset();
        reset = 1;
        rsp_ready = 1;
        idle();
        cycle();
        reset = 0;
    endtask

    function automatic logic [XLEN-1:0] rand_op();
        return ($urandom_range(3) == 0) ? XLEN'($urandom_range(15)) : XLEN'($urandom);
    endfunction

    initial begin
        m_s1 = '{0, 0, '0};
        m_s2 = '{0, 0, '0};
        m_ptr = 0;
        m_last = '{default: '0};
        do_reset();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_alu_ctl", {alu_sub, alu_ashr, alu_w, alu_funct3}, 0);
        check("rst_alu_op1", alu_op1, 0);
        check("rst_alu_op2", alu_op2, 0);
        check("rst_s1_valid", dut.s1_valid_q, 0);
        check("rst_ptr", dut.u_arb.ptr_q, 0);

        // single add from requester 0
        set_req(0, 1, ADD, 5, 3, 2'b00);
        cycle();
        idle();
        cycle();
        check("d39_valid", rsp_valid, 1);
        check("d39_id", rsp_id, 0);
        check("d39_result", rsp_result, 8);
        cycle();

        // both requesters valid: alternate grants starting at requester 0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                set_req(0, 1, ADD, XLEN'(i), 100, 2'b00);
                set_req(1, 1, ADD, XLEN'(i), 200, 2'b00);
                #1;
                check("d40_grant1", req1_ready, XLEN'(i % 2));
            end else idle();
            cycle();
            if (i >= 1) check("d40_rsp_id", rsp_id, XLEN'((i - 1) % 2));
        end
        idle();
        cycle();
        cycle();

        // three-cycle stall with both stages full
        do_reset();
        set_req(0, 1, ADD, 10, 1, 2'b00);
        cycle();
        set_req(0, 1, ADD, 20, 2, 2'b00);
        cycle();
        set_req(0, 1, ADD, 30, 3, 2'b00);
        rsp_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("d41_ready0", req0_ready, 0);
            check("d41_rsp_result", rsp_result, 11);
            check("d41_alu_op1", alu_op1, 20);
            cycle();
        end
        rsp_ready = 1;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();

        // forward the live S1 result into op1
        do_reset();
        set_req(0, 1, ADD, 5, 3, 2'b00);
        cycle();
        set_req(0, 1, ADD, 0, 1, 2'b10);
        cycle();
        idle();
        check("d42_first", rsp_result, 8);
        cycle();
        check("d42_second", rsp_result, EXP42);
        cycle();

        // forward a completed requester-1 result while S1 holds requester 0
        do_reset();
        set_req(1, 1, ADD, 3, 4, 2'b00);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        set_req(0, 1, ADD, 100, 1, 2'b00);
        cycle();
        set_req(0, 0, ADD, 0, 0, 2'b00);
        set_req(1, 1, SUB, 10, 0, 2'b01);
        cycle();
        idle();
        cycle();
        check("d43_id", rsp_id, 1);
        check("d43_result", rsp_result, EXP43);
        cycle();

        // reset with both stages occupied
        do_reset();
        set_req(0, 1, ADD, 1, 1, 2'b00);
        cycle();
        set_req(0, 1, ADD, 2, 2, 2'b00);
        cycle();
        check("d44_ptr_before", dut.u_arb.ptr_q, 1);
        do_reset();
        check("d44_rsp_valid", rsp_valid, 0);
        check("d44_s1_valid", dut.s1_valid_q, 0);
        check("d44_ptr", dut.u_arb.ptr_q, 0);
        for (int i = 0; i < 3; i++) cycle();

        // randomized traffic with back-pressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            rsp_ready = ($urandom_range(3) != 0);
            for (int n = 0; n < 2; n++)
                set_req(n[0], 1'($urandom_range(1)), 6'($urandom), rand_op(), rand_op(), 2'($urandom));
            cycle();
        end
        reset = 0;
        rsp_ready = 1;
        idle();
        for (int i = 0; i < 3; i++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
